// File: rtl/newcpla1_12_preimage_enum.sv
// Preimage enumerator for the newcpla1 output-12 cone: walks all 512 input
// vectors in ascending order and streams every vector whose y0 equals the target.
module newcpla1_12_preimage_enum #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             target,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [8:0]       out_vec,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t           r_state, w_nextState;
  logic [8:0]       r_cand, w_nextCand;
  logic [8:0]       r_outVec, w_nextOutVec;
  logic             r_outValid, w_nextOutValid;
  logic             r_target, w_nextTarget;
  logic             r_done, w_nextDone;
  logic [CNT_W-1:0] r_count, w_nextCount;
  logic             w_y0;
  logic             w_stall;

  // The embedded cone; x8 does not participate.
  assign w_y0 = ~r_cand[0] & r_cand[4] & r_cand[5] & r_cand[7] &
                (r_cand[3] ? r_cand[6] : (r_cand[2] & (~r_cand[1] | r_cand[6])));

  assign w_stall = r_outValid & ~out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cand     <= '0;
      r_outVec   <= '0;
      r_outValid <= 1'b0;
      r_target   <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_nextState;
      r_cand     <= w_nextCand;
      r_outVec   <= w_nextOutVec;
      r_outValid <= w_nextOutValid;
      r_target   <= w_nextTarget;
      r_done     <= w_nextDone;
      r_count    <= w_nextCount;
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_nextCand     = r_cand;
    w_nextOutVec   = r_outVec;
    w_nextOutValid = r_outValid;
    w_nextTarget   = r_target;
    w_nextDone     = 1'b0;
    w_nextCount    = r_count;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextTarget = target;
          w_nextCand   = '0;
          w_nextCount  = '0;
          w_nextState  = SCAN;
        end
      end

      SCAN: begin
        // A stalled output register freezes the whole pipeline so no candidate is lost.
        if (!w_stall) begin
          if (w_y0 == r_target) begin
            w_nextOutVec   = r_cand;
            w_nextOutValid = 1'b1;
            if (r_count != CNT_W'(512)) begin
              w_nextCount = r_count + CNT_W'(1);
            end
          end else begin
            w_nextOutValid = 1'b0;
          end
          if (r_cand == 9'd511) begin
            w_nextState = DRAIN;
          end else begin
            w_nextCand = r_cand + 9'd1;
          end
        end
      end

      DRAIN: begin
        // Finishing on any unstalled edge retires a pending final match in the same edge.
        if (!w_stall) begin
          w_nextOutValid = 1'b0;
          w_nextState    = IDLE;
          w_nextDone     = 1'b1;
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign out_valid = r_outValid;
  assign out_vec   = r_outVec;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign count     = r_count;

endmodule
